// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the iteration-counter width function.
package seq_div_pkg;

    // RUN and FIN each own one state bit, so busy/done are plain flop bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration built on a WIDTH+1-bit
// borrow chain: shift in one dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic             qbit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             qbit_out
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] b;
    logic [WIDTH:0] d;
    logic [WIDTH:0] borrow;

    assign t         = {r, qbit_in};
    assign b         = {1'b0, divisor};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_borrow
            assign d[gi] = t[gi] ^ b[gi] ^ borrow[gi];
            if (gi < WIDTH) begin : g_carry
                assign borrow[gi+1] = (~t[gi] & b[gi]) | (~(t[gi] ^ b[gi]) & borrow[gi]);
            end
        end
    endgenerate

    // d[WIDTH] acts as the sign of T - divisor; the kept remainder always fits WIDTH bits.
    assign qbit_out = ~d[WIDTH];
    assign r_next   = d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] r_reg, q_reg, div_reg;
    logic [WIDTH-1:0] r_step, q_step;
    logic             qbit;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg;
    logic [WIDTH-1:0] dividend_mag, divisor_mag, q_fix, r_fix;
    logic             accept, zero_div, last_iter;

    assign accept    = (state_reg == IDLE) && start;
    assign zero_div  = (divisor == '0);
    assign last_iter = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .r        (r_reg),
        .qbit_in  (q_reg[WIDTH-1]),
        .divisor  (div_reg),
        .r_next   (r_step),
        .qbit_out (qbit)
    );

    assign q_step = {q_reg[WIDTH-2:0], qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_reg, neg_r_reg;

    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix        = neg_q_reg ? -q_step : q_step;
    assign r_fix        = neg_r_reg ? -r_step : r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (accept) begin
            neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_reg <= dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_fix        = q_step;
    assign r_fix        = r_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = zero_div ? FIN : RUN;
            RUN:     if (last_iter) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            div_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            if (accept && !zero_div) begin
                cnt_reg <= '0;
                r_reg   <= '0;
                q_reg   <= dividend_mag;
                div_reg <= divisor_mag;
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + CW'(1);
                r_reg   <= r_step;
                q_reg   <= q_step;
            end
            // Results land on the edge entering FIN, so they are valid with done.
            if (accept && zero_div) begin
                quotient_reg  <= '1;
                remainder_reg <= dividend;
                dbz_reg       <= 1'b1;
            end else if (last_iter) begin
                quotient_reg  <= q_fix;
                remainder_reg <= r_fix;
                dbz_reg       <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): latency, results, divide by
// zero, ignored start while busy and reset during an operation.
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] quotient, remainder;

    int n_cmp = 0;
    int n_mis = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Issue one start and wait (bounded) for done; n counts cycles after the accepting edge.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                           input int elat);
        int  n;
        logic busy1;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        n = 1;
        busy1 = busy;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, " latency"}, n, elat);
        check_eq({tag, " busy1"}, {31'd0, busy1}, {31'd0, (elat > 1)});
        check_eq({tag, " busy_fin"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " quot"}, {24'd0, quotient}, {24'd0, eq});
        check_eq({tag, " rem"}, {24'd0, remainder}, {24'd0, er});
        check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        @(posedge clk);
        #1;
        check_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [7:0] q_seen, r_seen;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        check_eq("reset done", {31'd0, done}, 32'd0);
        check_eq("reset quot", {24'd0, quotient}, 32'd0);
        check_eq("reset rem", {24'd0, remainder}, 32'd0);
        check_eq("reset dbz", {31'd0, div_by_zero}, 32'd0);

        run_div("200/7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        dividend = 8'd99;
        divisor  = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrun busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rstrun busy", {31'd0, busy}, 32'd0);
        check_eq("rstrun done", {31'd0, done}, 32'd0);
        check_eq("rstrun quot", {24'd0, quotient}, 32'd0);
        check_eq("rstrun rem", {24'd0, remainder}, 32'd0);
        check_eq("rstrun dbz", {31'd0, div_by_zero}, 32'd0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check_eq("rstrun no_done", dones, 0);

        run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        run_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
        run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
        run_div("77/0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1, 1);

        // Second start two cycles into the operation must be ignored.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        q_seen = '0;
        r_seen = '0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) begin
                dividend = 8'd50;
                divisor  = 8'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                q_seen = quotient;
                r_seen = remainder;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_eq("busy_start dones", dones, 1);
        check_eq("busy_start quot", {24'd0, q_seen}, 32'd33);
        check_eq("busy_start rem", {24'd0, r_seen}, 32'd1);

        run_div("50/5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);
        run_div("dbz_again", 8'd12, 8'd0, 8'd255, 8'd12, 1'b1, 1);
        run_div("13/4", 8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 9);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("-7/2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9);
        run_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
        run_div("7/-2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
`else
        run_div("249/2", 8'hF9, 8'd2, 8'd124, 8'd1, 1'b0, 9);
        run_div("128/255", 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
